// File: rtl/cpu_pkg.sv
// Shared definitions for the issue-stage register status table:
// default sizes, the per-register status record and index-width helpers.
package cpu_pkg;

    localparam int NUM_REGS_DEFAULT = 32;
    localparam int TAG_W_DEFAULT    = 4;

    typedef struct packed {
        logic                     busy;
        logic [TAG_W_DEFAULT-1:0] tag;
    } reg_status_t;

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/reg_status_table_if.sv
// Issue/commit/ROB-facing bundle of the register status table.
// The master side is the issue/ROB logic; the slave side is the table.
interface reg_status_table_if
    import cpu_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEFAULT,
    parameter int TAG_W    = TAG_W_DEFAULT
);
    localparam int IDX_W = idx_width(NUM_REGS);
    localparam int CNT_W = cnt_width(NUM_REGS);

    logic             lookup_valid;
    logic [IDX_W-1:0] src1_idx;
    logic [IDX_W-1:0] src2_idx;
    logic             rsp_valid;
    logic             src1_busy;
    logic             src2_busy;
    logic [TAG_W-1:0] src1_tag;
    logic [TAG_W-1:0] src2_tag;
    logic             alloc_en;
    logic [IDX_W-1:0] alloc_idx;
    logic [TAG_W-1:0] alloc_tag;
    logic             commit_en;
    logic [IDX_W-1:0] commit_idx;
    logic [TAG_W-1:0] commit_tag;
    logic             flush;
    logic [IDX_W-1:0] probe_idx;
    logic             probe_busy;
    logic [TAG_W-1:0] probe_tag;
    logic [CNT_W-1:0] busy_count;

    modport master (
        output lookup_valid, src1_idx, src2_idx,
        output alloc_en, alloc_idx, alloc_tag,
        output commit_en, commit_idx, commit_tag,
        output flush, probe_idx,
        input  rsp_valid, src1_busy, src2_busy, src1_tag, src2_tag,
        input  probe_busy, probe_tag, busy_count
    );

    modport slave (
        input  lookup_valid, src1_idx, src2_idx,
        input  alloc_en, alloc_idx, alloc_tag,
        input  commit_en, commit_idx, commit_tag,
        input  flush, probe_idx,
        output rsp_valid, src1_busy, src2_busy, src1_tag, src2_tag,
        output probe_busy, probe_tag, busy_count
    );

endinterface

// File: rtl/reg_status_table_entry.sv
// One architectural register's busy/tag state with flush > alloc > commit
// priority; exposes both the stored state and the state it will take next.
module reg_status_entry
    import cpu_pkg::*;
#(
    parameter int TAG_W = TAG_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             alloc_hit,
    input  logic [TAG_W-1:0] alloc_tag,
    input  logic             commit_hit,
    input  logic [TAG_W-1:0] commit_tag,
    output logic             cur_busy,
    output logic [TAG_W-1:0] cur_tag,
    output logic             nxt_busy,
    output logic [TAG_W-1:0] nxt_tag
);

    // NOTE: both outputs get a default before any branch so no path leaves them unassigned (no latch).
    always_comb begin
        nxt_busy = cur_busy;
        nxt_tag  = cur_tag;
        if (flush) begin
            nxt_busy = 1'b0;
            nxt_tag  = '0;
        end else if (alloc_hit) begin
            nxt_busy = 1'b1;
            nxt_tag  = alloc_tag;
        end else if (commit_hit && cur_busy && (cur_tag == commit_tag)) begin
            // A free register always reads tag 0, so the tag is cleared with busy.
            nxt_busy = 1'b0;
            nxt_tag  = '0;
        end
    end

    // NOTE: state flops use non-blocking assignments so every entry samples the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_busy <= 1'b0;
            cur_tag  <= '0;
        end else begin
            cur_busy <= nxt_busy;
            cur_tag  <= nxt_tag;
        end
    end

endmodule

// File: rtl/reg_status_table.sv
// Register status table for the Tomasulo issue stage: per-register pending
// ROB tag, bypassed registered source lookup, ROB probe and busy counter.
module reg_status_table
    import cpu_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEFAULT,
    parameter int TAG_W    = TAG_W_DEFAULT,
    parameter bit ZERO_REG = 1'b1
) (
    input logic               clk,
    input logic               rst,
    reg_status_table_if.slave bus
);

    localparam int IDX_W = idx_width(NUM_REGS);
    localparam int CNT_W = cnt_width(NUM_REGS);

    logic [NUM_REGS-1:0] alloc_hit;
    logic [NUM_REGS-1:0] commit_hit;
    logic [NUM_REGS-1:0] cur_busy;
    logic [NUM_REGS-1:0] nxt_busy;
    logic [TAG_W-1:0]    cur_tag [NUM_REGS];
    logic [TAG_W-1:0]    nxt_tag [NUM_REGS];

    // Out-of-range indices match no entry, so alloc/commit to them fall through.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_entry
        assign alloc_hit[i]  = bus.alloc_en && (bus.alloc_idx == IDX_W'(i))
                               && !(ZERO_REG && (i == 0));
        assign commit_hit[i] = bus.commit_en && (bus.commit_idx == IDX_W'(i));

        reg_status_entry #(.TAG_W(TAG_W)) u_entry (
            .clk        (clk),
            .rst        (rst),
            .flush      (bus.flush),
            .alloc_hit  (alloc_hit[i]),
            .alloc_tag  (bus.alloc_tag),
            .commit_hit (commit_hit[i]),
            .commit_tag (bus.commit_tag),
            .cur_busy   (cur_busy[i]),
            .cur_tag    (cur_tag[i]),
            .nxt_busy   (nxt_busy[i]),
            .nxt_tag    (nxt_tag[i])
        );
    end

    logic             src1_busy_d;
    logic             src2_busy_d;
    logic [TAG_W-1:0] src1_tag_d;
    logic [TAG_W-1:0] src2_tag_d;

    // Lookups read next state (bypass); the probe reads stored state. A
    // missing match (out of range) and a gated register 0 both read as 0.
    always_comb begin
        src1_busy_d    = 1'b0;
        src1_tag_d     = '0;
        src2_busy_d    = 1'b0;
        src2_tag_d     = '0;
        bus.probe_busy = 1'b0;
        bus.probe_tag  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.src1_idx == IDX_W'(i)) begin
                src1_busy_d = nxt_busy[i];
                src1_tag_d  = nxt_tag[i];
            end
            if (bus.src2_idx == IDX_W'(i)) begin
                src2_busy_d = nxt_busy[i];
                src2_tag_d  = nxt_tag[i];
            end
            if (bus.probe_idx == IDX_W'(i)) begin
                bus.probe_busy = cur_busy[i];
                bus.probe_tag  = cur_tag[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rsp_valid <= 1'b0;
            bus.src1_busy <= 1'b0;
            bus.src1_tag  <= '0;
            bus.src2_busy <= 1'b0;
            bus.src2_tag  <= '0;
        end else begin
            bus.rsp_valid <= bus.lookup_valid;
            if (bus.lookup_valid) begin
                bus.src1_busy <= src1_busy_d;
                bus.src1_tag  <= src1_tag_d;
                bus.src2_busy <= src2_busy_d;
                bus.src2_tag  <= src2_tag_d;
            end
        end
    end

    // Outside flush at most one register rises (alloc) and one falls (commit).
    logic rises;
    logic falls;
    assign rises = |(nxt_busy & ~cur_busy);
    assign falls = |(cur_busy & ~nxt_busy);

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            bus.busy_count <= '0;
        end else begin
            bus.busy_count <= bus.busy_count + CNT_W'(rises) - CNT_W'(falls);
        end
    end

endmodule

// File: tb/tb_reg_status_table.sv
// Self-checking bench for reg_status_table: directed scenarios with literal
// expectations, then randomized traffic against an array-based model.
module tb_reg_status_table;
    import cpu_pkg::*;

    localparam int NR    = 24;
    localparam int TW    = TAG_W_DEFAULT;
    localparam bit ZR    = 1'b1;
    localparam int IDX_W = idx_width(NR);

    typedef struct {
        bit rst;
        bit lv;
        int s1, s2;
        bit ae;
        int ai, at;
        bit ce;
        int ci, ct;
        bit fl;
        int pi;
    } stim_t;

    logic clk;
    logic rst;
    reg_status_table_if #(.NUM_REGS(NR), .TAG_W(TW)) bus ();

    reg_status_table #(.NUM_REGS(NR), .TAG_W(TW), .ZERO_REG(ZR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit live  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the register file of pending tags plus expected response.
    reg_status_t m_state [NR];
    int e_rv, e_b1, e_t1, e_b2, e_t2;

    function automatic reg_status_t model_read(input int idx);
        reg_status_t z = '0;
        if (idx >= NR) return z;
        if (ZR && idx == 0) return z;
        return m_state[idx];
    endfunction

    function automatic int model_count();
        int c = 0;
        foreach (m_state[i]) c += int'(m_state[i].busy);
        return c;
    endfunction

    function automatic void model_apply(input stim_t s);
        reg_status_t r;
        if (s.rst) begin
            foreach (m_state[i]) m_state[i] = '0;
            e_rv = 0; e_b1 = 0; e_t1 = 0; e_b2 = 0; e_t2 = 0;
            return;
        end
        if (s.fl) begin
            foreach (m_state[i]) m_state[i] = '0;
        end else begin
            if (s.ce && s.ci < NR && m_state[s.ci].busy && int'(m_state[s.ci].tag) == s.ct)
                m_state[s.ci] = '0;
            // Alloc applied last so it overrides a same-register commit.
            if (s.ae && s.ai < NR && !(ZR && s.ai == 0)) begin
                m_state[s.ai].busy = 1'b1;
                m_state[s.ai].tag  = TW'(s.at);
            end
        end
        e_rv = int'(s.lv);
        if (s.lv) begin
            r = model_read(s.s1); e_b1 = int'(r.busy); e_t1 = int'(r.tag);
            r = model_read(s.s2); e_b2 = int'(r.busy); e_t2 = int'(r.tag);
        end
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.rst = 0; s.lv = 0; s.s1 = 0; s.s2 = 0; s.ae = 0; s.ai = 0; s.at = 0;
        s.ce = 0; s.ci = 0; s.ct = 0; s.fl = 0; s.pi = 0;
        return s;
    endfunction

    task automatic step(input stim_t s);
        rst              = s.rst;
        bus.lookup_valid = s.lv;
        bus.src1_idx     = IDX_W'(s.s1);
        bus.src2_idx     = IDX_W'(s.s2);
        bus.alloc_en     = s.ae;
        bus.alloc_idx    = IDX_W'(s.ai);
        bus.alloc_tag    = TW'(s.at);
        bus.commit_en    = s.ce;
        bus.commit_idx   = IDX_W'(s.ci);
        bus.commit_tag   = TW'(s.ct);
        bus.flush        = s.fl;
        bus.probe_idx    = IDX_W'(s.pi);
        @(posedge clk);
        #1;
        model_apply(s);
    endtask

    task automatic alloc(input int idx, input int tag);
        stim_t s = idle();
        s.ae = 1; s.ai = idx; s.at = tag;
        step(s);
    endtask

    // Every-cycle comparison of all outputs against the model.
    reg_status_t cmp_p;
    always @(negedge clk) begin
        if (live) begin
            cmp_p = model_read(int'(bus.probe_idx));
            check("rsp_valid",  int'(bus.rsp_valid),  e_rv);
            check("src1_busy",  int'(bus.src1_busy),  e_b1);
            check("src1_tag",   int'(bus.src1_tag),   e_t1);
            check("src2_busy",  int'(bus.src2_busy),  e_b2);
            check("src2_tag",   int'(bus.src2_tag),   e_t2);
            check("probe_busy", int'(bus.probe_busy), int'(cmp_p.busy));
            check("probe_tag",  int'(bus.probe_tag),  int'(cmp_p.tag));
            check("busy_count", int'(bus.busy_count), model_count());
        end
    end

    initial begin
        stim_t s;
        int    q[$];

        s = idle(); s.rst = 1;
        step(s);
        step(s);
        live = 1'b1;

        // Reset state, then first lookup.
        check("rst_rsp_valid", int'(bus.rsp_valid), 0);
        s = idle(); s.lv = 1; s.s1 = 3; s.s2 = 5;
        step(s);
        check("tp1_rsp_valid", int'(bus.rsp_valid), 1);
        check("tp1_busy1", int'(bus.src1_busy), 0);
        check("tp1_tag2", int'(bus.src2_tag), 0);
        check("tp1_count", int'(bus.busy_count), 0);
        step(idle());
        check("tp1_pulse_end", int'(bus.rsp_valid), 0);

        // Alloc r3, lookup r3/r0; register 0 stays free.
        alloc(3, 7);
        s = idle(); s.lv = 1; s.s1 = 3; s.s2 = 0;
        step(s);
        check("tp2_busy1", int'(bus.src1_busy), 1);
        check("tp2_tag1", int'(bus.src1_tag), 7);
        check("tp2_busy2", int'(bus.src2_busy), 0);
        check("tp2_count", int'(bus.busy_count), 1);
        check("tp2_model_count", model_count(), 1);
        s = idle(); s.ae = 1; s.ai = 0; s.at = 2; s.pi = 0;
        step(s);
        check("tp2_r0_probe", int'(bus.probe_busy), 0);
        check("tp2_r0_count", int'(bus.busy_count), 1);

        // Stale commit ignored, matching commit frees.
        alloc(3, 7);
        alloc(3, 9);
        s = idle(); s.ce = 1; s.ci = 3; s.ct = 7; s.lv = 1; s.s1 = 3; s.pi = 3;
        step(s);
        check("tp3_busy", int'(bus.src1_busy), 1);
        check("tp3_tag", int'(bus.src1_tag), 9);
        check("tp3_probe_tag", int'(bus.probe_tag), 9);
        s = idle(); s.ce = 1; s.ci = 3; s.ct = 9; s.pi = 3;
        step(s);
        check("tp3_free", int'(bus.probe_busy), 0);
        check("tp3_count", int'(bus.busy_count), 0);

        // Alloc + commit + lookup on one register in one cycle.
        s = idle(); s.ae = 1; s.ai = 4; s.at = 5; s.ce = 1; s.ci = 4; s.ct = 0;
        s.lv = 1; s.s1 = 4;
        step(s);
        check("tp4_busy", int'(bus.src1_busy), 1);
        check("tp4_tag", int'(bus.src1_tag), 5);
        check("tp4_count", int'(bus.busy_count), 1);

        // Out-of-range alloc/commit/lookup.
        s = idle(); s.ae = 1; s.ai = 30; s.at = 3; s.ce = 1; s.ci = 4; s.ct = 5;
        s.lv = 1; s.s1 = 30; s.s2 = 4;
        step(s);
        check("oor_busy", int'(bus.src1_busy), 0);
        check("oor_commit_r4", int'(bus.src2_busy), 0);
        check("oor_count", int'(bus.busy_count), 0);

        // Flush beats a same-cycle alloc.
        for (int i = 1; i <= 10; i++) alloc(i, i + 2);
        check("tp5_count_pre", int'(bus.busy_count), 10);
        s = idle(); s.fl = 1; s.ae = 1; s.ai = 11; s.at = 6; s.lv = 1; s.s1 = 2; s.pi = 11;
        step(s);
        check("tp5_rsp_valid", int'(bus.rsp_valid), 1);
        check("tp5_busy", int'(bus.src1_busy), 0);
        check("tp5_count", int'(bus.busy_count), 0);
        check("tp5_r11", int'(bus.probe_busy), 0);

        // Reset mid-operation drops the lookup and clears everything.
        for (int i = 1; i <= 6; i++) alloc(i + 10, i);
        check("tp6_count_pre", int'(bus.busy_count), 6);
        s = idle(); s.rst = 1; s.lv = 1; s.s1 = 11; s.s2 = 12;
        step(s);
        check("tp6_rsp_valid", int'(bus.rsp_valid), 0);
        check("tp6_count", int'(bus.busy_count), 0);
        for (int i = 0; i < 32; i++) begin
            s = idle(); s.pi = i;
            step(s);
            check("tp6_probe", int'(bus.probe_busy) + int'(bus.probe_tag), 0);
        end

        // Randomized traffic; commits mostly target pending registers.
        for (int n = 0; n < 3000; n++) begin
            s = idle();
            s.rst = ($urandom_range(0, 199) == 0);
            s.fl  = ($urandom_range(0, 39) == 0);
            s.lv  = ($urandom_range(0, 9) < 7);
            s.s1  = $urandom_range(0, 31);
            s.s2  = ($urandom_range(0, 3) == 0) ? s.s1 : $urandom_range(0, 31);
            s.ae  = ($urandom_range(0, 1) == 1);
            s.ai  = $urandom_range(0, 31);
            s.at  = $urandom_range(0, 15);
            s.ce  = ($urandom_range(0, 1) == 1);
            s.ci  = $urandom_range(0, 31);
            s.ct  = $urandom_range(0, 15);
            s.pi  = $urandom_range(0, 31);
            q.delete();
            foreach (m_state[i]) if (m_state[i].busy) q.push_back(i);
            if (q.size() > 0 && $urandom_range(0, 2) != 0) begin
                s.ci = q[$urandom_range(0, q.size() - 1)];
                if ($urandom_range(0, 3) != 0) s.ct = int'(m_state[s.ci].tag);
                if ($urandom_range(0, 4) == 0) s.ai = s.ci;
            end
            if ($urandom_range(0, 3) == 0) s.s1 = s.ai;
            step(s);
        end

        live = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_status_table.md
# reg_status_table

Parametrised register-status table for the Tomasulo issue stage. For each architectural register it tracks whether a pending reorder-buffer (ROB) entry will produce the register's value, and that entry's tag. Issue logic queries it for source-operand tags through a registered lookup with a valid pulse. Issue writes new destination tags; commit clears them, but only while the stored tag still matches the committing entry. A flush clears every pending tag at once.

## Interface
- NUM_REGS, 32, number of architectural registers (≥2).
- TAG_W, 4, ROB tag width (ROB depth = 2**TAG_W).
- ZERO_REG, 1, when 1, register 0 is never busy.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- lookup_valid  in  1  source query request.
- src1_idx, src2_idx  in  $clog2(NUM_REGS) each  source register indices.
- rsp_valid  out  1  one-cycle pulse, response fields valid.
- src1_busy, src2_busy  out  1 each  register awaits a ROB result.
- src1_tag, src2_tag  out  TAG_W each  producing ROB tag, 0 when not busy.
- alloc_en  in  1  record a new destination mapping.
- alloc_idx  in  $clog2(NUM_REGS)  destination register.
- alloc_tag  in  TAG_W  ROB tag of the issuing instruction.
- commit_en  in  1  ROB commit of a register-writing entry.
- commit_idx  in  $clog2(NUM_REGS)  committed destination.
- commit_tag  in  TAG_W  committing ROB tag.
- flush  in  1  clear all mappings (mispredict or exception).
- probe_idx  in  $clog2(NUM_REGS)  combinational probe for the ROB.
- probe_busy, probe_tag  out  1 / TAG_W  current state of probe_idx, no bypass.
- busy_count  out  $clog2(NUM_REGS+1)  number of busy registers.

## Operation
- Per-register state is a busy bit plus a TAG_W tag. Reset and flush set all busy bits to 0 and all tags to 0.
- Next-state update, in priority order per register:
  - flush: clears all registers and overrides every other input.
  - alloc: when alloc_en is set and alloc_idx matches, busy=1 and tag=alloc_tag.
  - commit: when commit_en is set, commit_idx matches and the stored tag equals commit_tag, busy=0.
- If alloc and commit target the same register in the same cycle, alloc wins: the new tag is kept and busy stays 1.
- A commit whose tag does not match the stored tag is ignored. The register was renamed again and must stay busy.
- With ZERO_REG=1:
  - alloc to index 0 is dropped.
  - lookups and probes of register 0 return busy=0, tag=0.
- Indices ≥ NUM_REGS:
  - alloc and commit are ignored.
  - lookup and probe return busy=0, tag=0.
- Lookup bypass: the response reflects the next state, i.e. after that cycle's alloc, commit and flush are applied. A source that equals the same-cycle alloc_idx returns the new tag.
- Out-of-range handling covers the old in-band sentinel encoding; busy is always a separate bit.
- busy_count is a registered counter updated incrementally:
  - +1 when a non-busy register becomes busy.
  - −1 when a busy register is cleared.
  - Net 0 for alloc onto an already-busy register.
  - Goes to 0 on flush or reset.
  - Must equal the popcount of the busy vector at all times.

## Timing
- Lookup latency is 1 cycle. lookup_valid sampled at edge N gives rsp_valid=1 and data after edge N, held for exactly one cycle.
- Back-to-back lookups give back-to-back responses. There is no backpressure.
- Response registers hold their last value when rsp_valid=0.
- Reset values: rsp_valid=0, all src*_busy=0, all src*_tag=0, busy_count=0; probe outputs read 0.
- rst asserted mid-operation:
  - A lookup issued in the same cycle is dropped (rsp_valid=0 next cycle).
  - All state clears at that edge.
- flush with lookup_valid gives rsp_valid=1 with all busy=0.
- probe outputs are purely combinational from the stored state.

## Structure
- A shared package (cpu_pkg) holds:
  - NUM_REGS_DEFAULT and TAG_W_DEFAULT.
  - A reg_status_t struct {busy, tag}.
  - The index width function.
- One sub-module, reg_status_entry, covers a single register's busy/tag flop with alloc/commit/flush priority. It is instantiated NUM_REGS times via generate, and exposes current and next state.
- The top level holds the decode of alloc/commit indices, the two bypassed read muxes, the probe mux, the response register and busy_count.

## Test plan
- Reset, then lookup regs 3/5 → next cycle rsp_valid=1, both busy=0, tag=0, busy_count=0.
- alloc r3 tag 7, then lookup r3/r0 → busy=1 tag=7 / busy=0; busy_count=1. alloc r0 tag 2 → r0 stays free, count stays 1.
- alloc r3 tag 7, alloc r3 tag 9, commit r3 tag 7 → r3 busy, tag 9. Then commit r3 tag 9 → r3 free, count 0.
- In the same cycle, alloc r4 tag 5 + commit r4 with the old tag + lookup src1=r4 → response busy=1 tag=5, count +1.
- Allocate r1..r10, then flush together with alloc r11 and lookup r2 → response busy=0, count=0, r11 free.
- Assert rst during a lookup with 6 busy regs → rsp_valid=0 next cycle, busy_count=0, probe of every reg reads 0.
